// File: rtl/adder_result_buffer.sv
// Capture FIFO for 4-bit adder results, replayed over a valid/ready handshake.
// Optional result checker built when RESULT_CHECK_EN is defined.
module adder_result_buffer #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [WIDTH-1:0]         in_a,
   input  logic [WIDTH-1:0]         in_b,
   input  logic [WIDTH-1:0]         in_sum,
   input  logic                     in_carry,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_a,
   output logic [WIDTH-1:0]         out_b,
   output logic [WIDTH-1:0]         out_sum,
   output logic                     out_carry,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     err,
   output logic [7:0]               err_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = 3*WIDTH + 1;

   logic [EW-1:0] mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;

   // MSB of each pointer is the wrap bit; it distinguishes full from empty
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign in_ready  = ~full;
   assign out_valid = ~empty;
   assign push      = in_valid && ~full;
   assign pop       = ~empty && out_ready;
   assign count     = wr_ptr - rd_ptr;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (in_valid && full)
            overflow <= 1'b1;
      end
   end

   // storage is intentionally not cleared by reset
   always_ff @(posedge clk) begin
      if (push && !reset)
         mem[wr_ptr[AW-1:0]] <= {in_a, in_b, in_carry, in_sum};
   end

   assign {out_a, out_b, out_carry, out_sum} = mem[rd_ptr[AW-1:0]];

`ifdef RESULT_CHECK_EN
   logic [WIDTH:0] sum_ref;
   logic           mismatch;

   assign sum_ref  = {1'b0, in_a} + {1'b0, in_b};
   assign mismatch = push && ({in_carry, in_sum} != sum_ref);

   always_ff @(posedge clk) begin
      if (reset) begin
         err       <= 1'b0;
         err_count <= '0;
      end else if (mismatch) begin
         err <= 1'b1;
         if (err_count != 8'hFF)
            err_count <= err_count + 8'd1;
      end
   end
`else
   assign err       = 1'b0;
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_adder_result_buffer.sv
// Scoreboard bench for adder_result_buffer: predictor queues expected entries,
// monitor compares the head and status every cycle.
module tb_adder_result_buffer;
   localparam int W = 4;
   localparam int D = 4;
`ifdef RESULT_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic [W-1:0] in_a, in_b, in_sum;
   logic         in_carry;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] out_a, out_b, out_sum;
   logic         out_carry;
   logic         out_ready;
   logic [2:0]   count;
   logic         overflow;
   logic         err;
   logic [7:0]   err_count;

   adder_result_buffer #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .in_carry(in_carry),
      .in_ready(in_ready),
      .out_valid(out_valid), .out_a(out_a), .out_b(out_b), .out_sum(out_sum), .out_carry(out_carry),
      .out_ready(out_ready),
      .count(count), .overflow(overflow), .err(err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int a;
      int b;
      int s;
      int c;
   } ent_t;

   ent_t exp_q[$];
   int   model_cnt = 0;
   bit   m_ovf = 0;
   bit   m_err = 0;
   int   m_errc = 0;
   bit   mon_en = 0;
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // predictor: decides acceptance from the model occupancy before each edge
   always @(posedge clk) begin
      if (reset) begin
         model_cnt = 0;
         exp_q.delete();
         m_ovf  = 0;
         m_err  = 0;
         m_errc = 0;
         mon_en = 1;
      end else if (mon_en) begin
         bit   do_push, do_pop;
         ent_t e;
         do_pop  = (model_cnt > 0) && out_ready;
         do_push = in_valid && (model_cnt < D);
         if (in_valid && model_cnt == D)
            m_ovf = 1;
         if (do_push) begin
            e.a = int'(in_a); e.b = int'(in_b); e.s = int'(in_sum); e.c = int'(in_carry);
            exp_q.push_back(e);
            if (CHK && (e.c*16 + e.s != e.a + e.b)) begin
               m_err = 1;
               if (m_errc < 255) m_errc++;
            end
         end
         model_cnt = model_cnt + int'(do_push) - int'(do_pop);
      end
   end

   // monitor: mid-cycle comparison of status and head entry
   always @(negedge clk) begin
      if (mon_en && !reset) begin
         chk("count", 32'(count), model_cnt);
         chk("out_valid", 32'(out_valid), 32'(model_cnt > 0));
         chk("in_ready", 32'(in_ready), 32'(model_cnt < D));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         chk("err", 32'(err), 32'(m_err));
         chk("err_count", 32'(err_count), m_errc);
         if (model_cnt > 0 && exp_q.size() > 0) begin
            chk("out_a", 32'(out_a), exp_q[0].a);
            chk("out_b", 32'(out_b), exp_q[0].b);
            chk("out_sum", 32'(out_sum), exp_q[0].s);
            chk("out_carry", 32'(out_carry), exp_q[0].c);
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input int a, input int b, input int s, input int c, input bit rdy);
      in_valid  = v;
      in_a      = W'(a);
      in_b      = W'(b);
      in_sum    = W'(s);
      in_carry  = c[0];
      out_ready = rdy;
      step();
   endtask

   task automatic drive_ok(input bit v, input int a, input int b, input bit rdy);
      drive(v, a, b, (a + b) % 16, (a + b) / 16, rdy);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (model_cnt != 0 && n < 20) begin
         drive(0, 0, 0, 0, 0, 1);
         n++;
      end
      chk("drain_timeout", model_cnt, 0);
   endtask

   initial begin
      reset = 1; in_valid = 0; in_a = '0; in_b = '0; in_sum = '0; in_carry = 0; out_ready = 0;
      step(); step();
      reset = 0;
      for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 0);

      // single pass-through
      drive(1, 9, 8, 1, 1, 1);
      drive(0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 1);

      // fill and overflow, then push/pop while full
      for (int i = 1; i <= 5; i++) drive(1, i, 0, i, 0, 0);
      drive(1, 6, 0, 6, 0, 1);
      drain();

      // back-to-back stream over all operand pairs
      for (int i = 0; i < 256; i++) drive_ok(1, i / 16, i % 16, 1);
      drain();

      // randomized traffic with occasional bad sums
      for (int i = 0; i < 400; i++) begin
         int a, b, s, c;
         a = int'($urandom_range(0, 15));
         b = int'($urandom_range(0, 15));
         s = (a + b) % 16;
         c = (a + b) / 16;
         if ($urandom_range(0, 15) == 0) s = s ^ 1;
         drive(($urandom_range(0, 3) != 0), a, b, s, c, ($urandom_range(0, 2) != 0));
      end
      drain();

      // checker hit, then reset with entries held
      reset = 1; step(); reset = 0;
      drive(1, 3, 3, 7, 0, 0);
      drive(1, 2, 2, 4, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      reset = 1; step(); reset = 0;
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/adder_result_buffer.md
# adder_result_buffer

Downstream capture stage for the 4-bit adder. Each cycle the adder presents a valid result, this block latches the operands and {carry, sum} into a small FIFO. It then replays the entries to a consumer over a valid/ready handshake, so results produced at full rate are not lost while the consumer (scoreboard port or next datapath stage) stalls. An optional built-in checker flags any result that disagrees with a + b.

## Interface
- WIDTH, 4: operand and sum width in bits.
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  adder result present this cycle.
- in_a, in_b  input  WIDTH  operands that produced the result.
- in_sum  input  WIDTH  adder sum.
- in_carry  input  1  adder carry-out.
- in_ready  output  1  buffer can accept; equals not-full.
- out_valid  output  1  head entry available.
- out_a, out_b  output  WIDTH  head entry operands.
- out_sum  output  WIDTH  head entry sum.
- out_carry  output  1  head entry carry.
- out_ready  input  1  consumer takes head entry.
- count  output  $clog2(DEPTH)+1  entries held.
- overflow  output  1  sticky; in_valid seen while full.
- err  output  1  sticky checker flag (RESULT_CHECK_EN only; tied 0 otherwise).
- err_count  output  8  checker mismatch count, saturating at 255 (RESULT_CHECK_EN only; tied 0 otherwise).

## Operation
- Storage: DEPTH entries of {a, b, carry, sum}, which is 3*WIDTH+1 bits each.
- Write pointer and read pointer are each $clog2(DEPTH)+1 bits. The MSB is the wrap bit.
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the MSBs differ.
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- Push and pop in the same cycle: both pointers advance and count is unchanged. This is legal when full (pop frees a slot, but in_ready is still low, so no push happens) and when empty (no pop, since out_valid is low).
- Push while full: the entry is dropped, the pointers are unchanged, and overflow sets and holds until reset.
- Outputs out_a, out_b, out_sum and out_carry are driven directly from the head entry. Their value is don't-care while out_valid = 0; the bench must not check them then.
- Reset: pointers = 0, count = 0, out_valid = 0, in_ready = 1, overflow = 0, err = 0, err_count = 0. Memory contents are not cleared.
- Reset asserted mid-stream discards all held entries. A push or pop in the reset cycle is ignored.

## Timing
- Latency from push to out_valid is 1 cycle: an entry pushed at edge N is visible at the head after edge N.
- No combinational path from in_valid to out_valid.
- in_ready depends only on registered state. It has no combinational dependence on out_ready.
- count, in_ready and out_valid all update on the same edge as the pointer change.
- Sustained throughput is 1 entry/cycle when out_ready is held high.
- Checker (when compiled in): compares {in_carry, in_sum} against in_a + in_b, computed at WIDTH+1 bits, on every accepted push.
  - On mismatch, err sets on the next edge and err_count increments on the same edge.
  - Dropped (overflow) pushes are not checked.

## Configuration
- RESULT_CHECK_EN defined: the checker logic, err and err_count are built as described above.
- RESULT_CHECK_EN undefined:
  - no checker logic is generated;
  - err and err_count are driven constant 0;
  - the ports remain present so the port list is identical in both builds.

## Test plan
- Reset then idle: after reset, expect count = 0, out_valid = 0, in_ready = 1, overflow = 0 for 5 cycles.
- Single pass-through: push a = 4'h9, b = 4'h8, sum = 4'h1, carry = 1 with out_ready = 1. Expect out_valid = 1 the next cycle with the same fields, and count returning to 0 the cycle after.
- Fill and overflow: with out_ready = 0, push 5 results (a = 1..5, b = 0).
  - Expect in_ready = 0 and count = 4 after the 4th push.
  - The 5th push sets overflow = 1.
  - Draining yields a = 1, 2, 3, 4 in order.
- Simultaneous push/pop while full: at count = 4, assert in_valid and out_ready. Expect count = 3 and the head advanced. The push is not accepted and overflow is unchanged.
- Back-to-back stream: push all 256 operand pairs for 4 bits over 256 consecutive cycles with out_ready = 1. Expect 256 in-order outputs, overflow = 0, and err_count = 0 with RESULT_CHECK_EN.
- Checker and reset: with RESULT_CHECK_EN, push a = 3, b = 3, sum = 7, carry = 0. Expect err = 1 and err_count = 1. Assert reset with 2 entries held; expect count = 0, out_valid = 0, err = 0 after the edge.
